imem_ctrl: RTL and testbench

Instruction-memory controller for the single-issue core. It owns the only port of the 4096×32 synchronous instruction RAM and shares it between two users: a program loader that writes words, and the core's fetch stage, which reads one instruction per cycle. It sequences the fetch PC, including stall, redirect and 12-bit wrap-around. It also gates core execution until a program has been loaded.

---
 rtl/imem_ctrl_if.sv | 39 +++
 rtl/imem_ctrl.sv | 103 ++++++++++
 tb/tb_imem_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/imem_ctrl_if.sv
// Loader, RAM-port and fetch signals of the instruction-memory controller.
// The slave modport is the controller side; master is its surroundings.
interface imem_ctrl_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   ld_cnt;
    logic              load_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              run;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;

    modport master (
        output ld_valid, ld_addr, ld_data, ld_done, load_req,
        output mem_rdata, stall, redirect, redirect_pc,
        input  ld_ready, ld_cnt, mem_addr, mem_we, mem_wdata,
        input  run, inst, inst_pc, inst_valid
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_done, load_req,
        input  mem_rdata, stall, redirect, redirect_pc,
        output ld_ready, ld_cnt, mem_addr, mem_we, mem_wdata,
        output run, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction-RAM port arbiter: loader writes in LOAD, sequential/redirected fetch in RUN.
// Fetch latency 1 cycle, 1 inst/cycle; loader never waits in LOAD, stall re-reads the held word.
module imem_ctrl #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESET_PC = 0,
    parameter bit          BOOT_RUN = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    imem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_LOAD, S_START, S_RUN} state_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam logic [ADDR_W-1:0] PC0     = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_f, pc_d;
    logic              vld_d;
    logic [ADDR_W:0]   ld_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT_RUN ? S_START : S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (bus.ld_done) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN:   if (bus.load_req) state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f     <= PC0;
            pc_d     <= PC0;
            vld_d    <= 1'b0;
            ld_cnt_q <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    // Top bit set means exactly 2^ADDR_W writes: hold there.
                    if (bus.ld_valid && !ld_cnt_q[ADDR_W]) ld_cnt_q <= ld_cnt_q + CNT_ONE;
                end
                S_START: begin
                    pc_d  <= PC0;
                    pc_f  <= PC0 + PC_ONE;
                    vld_d <= 1'b1;
                end
                S_RUN: begin
                    if (bus.load_req) begin
                        ld_cnt_q <= '0;
                        vld_d    <= 1'b0;
                    end else if (bus.redirect) begin
                        pc_d <= bus.redirect_pc;
                        pc_f <= bus.redirect_pc + PC_ONE;
                    end else if (!bus.stall) begin
                        pc_d <= pc_f;
                        pc_f <= pc_f + PC_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are qualified by rst_n so reset blocks a write without waiting for an edge.
    always_comb begin
        bus.mem_addr   = pc_f;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = word_t'(bus.ld_data);
        bus.ld_ready   = 1'b0;
        bus.ld_cnt     = ld_cnt_q;
        bus.run        = 1'b0;
        bus.inst       = bus.mem_rdata;
        bus.inst_pc    = pc_d;
        bus.inst_valid = 1'b0;
        case (state)
            S_LOAD: begin
                bus.ld_ready = rst_n;
                bus.mem_we   = rst_n & bus.ld_valid;
                bus.mem_addr = bus.ld_addr;
            end
            S_START: bus.mem_addr = PC0;
            S_RUN: begin
                bus.run        = rst_n;
                bus.inst_valid = rst_n & vld_d;
                if (bus.load_req)      bus.mem_addr = pc_f;
                else if (bus.redirect) bus.mem_addr = bus.redirect_pc;
                else if (bus.stall)    bus.mem_addr = pc_d;
                else                   bus.mem_addr = pc_f;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: load/fetch/stall/redirect/reload vectors plus
// counter saturation, reset mid-load and a BOOT_RUN instance.
module tb_imem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    imem_ctrl_if #(.ADDR_W(12), .DATA_W(32)) a ();
    imem_ctrl_if #(.ADDR_W(12), .DATA_W(32)) b ();

    imem_ctrl #(.ADDR_W(12), .DATA_W(32), .RESET_PC(0), .BOOT_RUN(1'b0))
        dut (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    imem_ctrl #(.ADDR_W(12), .DATA_W(32), .RESET_PC(16), .BOOT_RUN(1'b1))
        dut_boot (.clk(clk), .rst_n(rst2_n), .bus(b.slave));

    // RAM models: unwritten words read as a recognisable address pattern.
    bit [31:0] ram [4096];
    bit        wr_seen [4096];
    always @(posedge clk) begin
        if (a.mem_we) begin
            ram[a.mem_addr]     <= a.mem_wdata;
            wr_seen[a.mem_addr] <= 1'b1;
        end
        a.mem_rdata <= wr_seen[a.mem_addr] ? ram[a.mem_addr] : (32'hA000_0000 | 32'(a.mem_addr));
    end

    bit ram2_written;
    always @(posedge clk) begin
        if (b.mem_we) ram2_written <= 1'b1;
        b.mem_rdata <= 32'hB000_0000 | 32'(b.mem_addr);
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic [11:0] addr;
        logic [31:0] data;
        logic        done, lreq, stall, redir;
        logic [11:0] rpc;
        logic        run, rdy, we, iv;
        logic [11:0] ipc;
        logic [31:0] inst;
        logic [12:0] cnt;
        logic [11:0] maddr;
        logic        chk_addr;
    } vec_t;

    vec_t vecs [19];

    task automatic idle_a();
        a.ld_valid = 0; a.ld_addr = '0; a.ld_data = '0; a.ld_done = 0;
        a.load_req = 0; a.stall = 0; a.redirect = 0; a.redirect_pc = '0;
    endtask

    initial begin
        //          vld addr    data        dn lq st rd rpc      run rdy we iv ipc     inst          cnt  maddr   ca
        vecs[0]  = '{1, 12'h000, 32'h11,   0, 0, 0, 0, 12'h000, 0, 1, 1, 0, 12'h000, 32'h0,       0, 12'h000, 1};
        vecs[1]  = '{1, 12'h001, 32'h22,   0, 0, 0, 0, 12'h000, 0, 1, 1, 0, 12'h000, 32'h0,       1, 12'h001, 1};
        vecs[2]  = '{1, 12'h002, 32'h33,   0, 0, 0, 0, 12'h000, 0, 1, 1, 0, 12'h000, 32'h0,       2, 12'h002, 1};
        vecs[3]  = '{1, 12'h003, 32'h44,   1, 0, 0, 0, 12'h000, 0, 1, 1, 0, 12'h000, 32'h0,       3, 12'h003, 1};
        vecs[4]  = '{1, 12'h007, 32'hDEAD, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 32'h0,       4, 12'h000, 1};
        vecs[5]  = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h000, 32'h11,      4, 12'h001, 1};
        vecs[6]  = '{0, 12'h000, 32'h0,    0, 0, 1, 0, 12'h000, 1, 0, 0, 1, 12'h001, 32'h22,      4, 12'h001, 1};
        vecs[7]  = '{0, 12'h000, 32'h0,    0, 0, 1, 0, 12'h000, 1, 0, 0, 1, 12'h001, 32'h22,      4, 12'h001, 1};
        vecs[8]  = '{0, 12'h000, 32'h0,    0, 0, 1, 0, 12'h000, 1, 0, 0, 1, 12'h001, 32'h22,      4, 12'h001, 1};
        vecs[9]  = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h001, 32'h22,      4, 12'h002, 1};
        vecs[10] = '{0, 12'h000, 32'h0,    0, 0, 1, 1, 12'hFFF, 1, 0, 0, 1, 12'h002, 32'h33,      4, 12'hFFF, 1};
        vecs[11] = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 1, 0, 0, 1, 12'hFFF, 32'hA0000FFF, 4, 12'h000, 1};
        vecs[12] = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h000, 32'h11,      4, 12'h001, 1};
        vecs[13] = '{0, 12'h000, 32'h0,    0, 1, 0, 0, 12'h000, 1, 0, 0, 1, 12'h001, 32'h22,      4, 12'h000, 0};
        vecs[14] = '{1, 12'h002, 32'hAB,   1, 0, 0, 0, 12'h000, 0, 1, 1, 0, 12'h000, 32'h0,       0, 12'h002, 1};
        vecs[15] = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 32'h0,       1, 12'h000, 1};
        vecs[16] = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h000, 32'h11,      1, 12'h001, 1};
        vecs[17] = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h001, 32'h22,      1, 12'h002, 1};
        vecs[18] = '{0, 12'h000, 32'h0,    0, 0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h002, 32'hAB,      1, 12'h003, 1};

        idle_a();
        b.ld_valid = 1; b.ld_addr = 12'h007; b.ld_data = 32'hDEAD_BEEF; b.ld_done = 0;
        b.load_req = 0; b.stall = 0; b.redirect = 0; b.redirect_pc = '0;

        // Reset state with a write request pending.
        a.ld_valid = 1;
        @(negedge clk); #1;
        check("rst_ld_ready", a.ld_ready, 0);
        check("rst_mem_we", a.mem_we, 0);
        check("rst_run", a.run, 0);
        check("rst_inst_valid", a.inst_valid, 0);
        check("rst_ld_cnt", a.ld_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        idle_a();

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            a.ld_valid = vecs[i].vld; a.ld_addr = vecs[i].addr; a.ld_data = vecs[i].data;
            a.ld_done = vecs[i].done; a.load_req = vecs[i].lreq; a.stall = vecs[i].stall;
            a.redirect = vecs[i].redir; a.redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_run", i), a.run, vecs[i].run);
            check($sformatf("v%0d_ld_ready", i), a.ld_ready, vecs[i].rdy);
            check($sformatf("v%0d_mem_we", i), a.mem_we, vecs[i].we);
            check($sformatf("v%0d_inst_valid", i), a.inst_valid, vecs[i].iv);
            check($sformatf("v%0d_ld_cnt", i), a.ld_cnt, vecs[i].cnt);
            if (vecs[i].chk_addr) check($sformatf("v%0d_mem_addr", i), a.mem_addr, vecs[i].maddr);
            if (vecs[i].iv) begin
                check($sformatf("v%0d_inst_pc", i), a.inst_pc, vecs[i].ipc);
                check($sformatf("v%0d_inst", i), a.inst, vecs[i].inst);
            end
        end
        check("start_ignores_ld_valid", wr_seen[7], 0);

        // Saturation: 4097 back-to-back writes must stop the count at 4096.
        @(negedge clk);
        idle_a();
        a.load_req = 1;
        @(negedge clk);
        idle_a();
        for (int i = 0; i < 4097; i++) begin
            a.ld_valid = 1; a.ld_addr = 12'(i); a.ld_data = 32'(i);
            @(negedge clk);
        end
        #1;
        check("sat_ld_cnt", a.ld_cnt, 13'h1000);
        check("sat_ld_ready", a.ld_ready, 1);
        check("midload_mem_we_before", a.mem_we, 1);

        // Reset asserted between edges while a write is being presented.
        rst_n = 0;
        #1;
        check("midload_mem_we", a.mem_we, 0);
        check("midload_ld_ready", a.ld_ready, 0);
        check("midload_ld_cnt", a.ld_cnt, 0);
        check("midload_run", a.run, 0);
        idle_a();

        // BOOT_RUN instance: START right out of reset, then fetch from RESET_PC=16.
        @(negedge clk);
        rst2_n = 1;
        #1;
        check("boot_start_run", b.run, 0);
        check("boot_start_inst_valid", b.inst_valid, 0);
        check("boot_start_ld_ready", b.ld_ready, 0);
        check("boot_start_mem_we", b.mem_we, 0);
        check("boot_start_mem_addr", b.mem_addr, 12'h010);
        @(negedge clk); #1;
        check("boot_run", b.run, 1);
        check("boot_inst_valid", b.inst_valid, 1);
        check("boot_inst_pc0", b.inst_pc, 12'h010);
        check("boot_inst0", b.inst, 32'hB000_0010);
        check("boot_ld_cnt", b.ld_cnt, 0);
        @(negedge clk); #1;
        check("boot_inst_pc1", b.inst_pc, 12'h011);
        check("boot_inst1", b.inst, 32'hB000_0011);
        check("boot_no_write", ram2_written, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
